// File: rtl/cache_miss_ctrl_4way.sv
// Read-miss controller for a 4-way L1 cache: looks the request up in L1, on a miss
// fetches the word from L2 over a valid/ready handshake, fills L1, then answers the CPU.
// One request in flight. Hit/miss/timeout counters saturate at all-ones.
module cache_miss_ctrl_4way #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32,
  parameter int L2_TIMEOUT = 64,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req_valid,
  output logic                  cpu_req_ready,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  output logic                  cpu_resp_valid,
  output logic [DATA_WIDTH-1:0] cpu_resp_data,
  output logic                  cpu_resp_hit,
  output logic                  cpu_resp_err,
  output logic                  l1_read,
  output logic                  l1_write_enable,
  output logic [ADDR_WIDTH-1:0] l1_addr,
  output logic [DATA_WIDTH-1:0] l1_write_data,
  input  logic [DATA_WIDTH-1:0] l1_read_data,
  input  logic                  l1_hit,
  output logic                  l2_req_valid,
  input  logic                  l2_req_ready,
  output logic [ADDR_WIDTH-1:0] l2_addr,
  input  logic                  l2_resp_valid,
  input  logic [DATA_WIDTH-1:0] l2_resp_data,
  output logic [CNT_WIDTH-1:0]  hit_count,
  output logic [CNT_WIDTH-1:0]  miss_count,
  output logic [CNT_WIDTH-1:0]  timeout_count
);

  localparam int TMR_W = $clog2(L2_TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(L2_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_CHECK, S_L2_REQ, S_L2_WAIT, S_FILL, S_RESPOND
  } state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  hit_q;
  logic                  err_q;
  logic [TMR_W-1:0]      timer;
  logic                  timer_done;

  assign timer_done = (timer == TMR_LAST);

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode; an L2 response in the last timer cycle still wins over the timeout.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:    if (cpu_req_valid) state_nxt = S_LOOKUP;
      S_LOOKUP:  state_nxt = S_CHECK;
      S_CHECK:   state_nxt = l1_hit ? S_RESPOND : S_L2_REQ;
      S_L2_REQ:  if (l2_req_ready) state_nxt = S_L2_WAIT;
      S_L2_WAIT: begin
        if (l2_resp_valid)   state_nxt = S_FILL;
        else if (timer_done) state_nxt = S_RESPOND;
      end
      S_FILL:    state_nxt = S_RESPOND;
      S_RESPOND: state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Request address, response payload, L2 wait timer and statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q        <= '0;
      hit_q         <= 1'b0;
      err_q         <= 1'b0;
      timer         <= '0;
      hit_count     <= '0;
      miss_count    <= '0;
      timeout_count <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (cpu_req_valid) begin
            addr_q <= cpu_addr;
            hit_q  <= 1'b0;
            err_q  <= 1'b0;
          end
        end
        S_CHECK: begin
          if (l1_hit) begin
            data_q    <= l1_read_data;
            hit_q     <= 1'b1;
            hit_count <= sat_inc(hit_count);
          end else begin
            miss_count <= sat_inc(miss_count);
          end
        end
        S_L2_REQ: timer <= '0;
        S_L2_WAIT: begin
          if (l2_resp_valid) begin
            data_q <= l2_resp_data;
          end else if (timer_done) begin
            data_q        <= '0;
            err_q         <= 1'b1;
            timeout_count <= sat_inc(timeout_count);
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Moore outputs; data buses are held at zero outside the cycle that qualifies them.
  always_comb begin
    cpu_req_ready   = (state == S_IDLE);
    l1_read         = (state == S_LOOKUP);
    l1_write_enable = (state == S_FILL);
    l1_write_data   = (state == S_FILL) ? data_q : '0;
    l1_addr         = addr_q;
    l2_req_valid    = (state == S_L2_REQ);
    l2_addr         = addr_q;
    cpu_resp_valid  = (state == S_RESPOND);
    cpu_resp_data   = (state == S_RESPOND) ? data_q : '0;
    cpu_resp_hit    = (state == S_RESPOND) && hit_q;
    cpu_resp_err    = (state == S_RESPOND) && err_q;
  end

endmodule

// File: tb/tb_cache_miss_ctrl_4way.sv
// Bench for cache_miss_ctrl_4way: a behavioural L1 array and a scripted L2 responder,
// with expected responses, latencies and counters derived from the transaction rules.
module tb_cache_miss_ctrl_4way;
  localparam int AW = 11;
  localparam int DW = 32;
  localparam int T  = 8;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cpu_req_valid = 1'b0;
  logic          cpu_req_ready;
  logic [AW-1:0] cpu_addr = '0;
  logic          cpu_resp_valid;
  logic [DW-1:0] cpu_resp_data;
  logic          cpu_resp_hit;
  logic          cpu_resp_err;
  logic          l1_read;
  logic          l1_write_enable;
  logic [AW-1:0] l1_addr;
  logic [DW-1:0] l1_write_data;
  logic [DW-1:0] l1_read_data = '0;
  logic          l1_hit = 1'b0;
  logic          l2_req_valid;
  logic          l2_req_ready = 1'b0;
  logic [AW-1:0] l2_addr;
  logic          l2_resp_valid = 1'b0;
  logic [DW-1:0] l2_resp_data = '0;
  logic [CW-1:0] hit_count, miss_count, timeout_count;

  cache_miss_ctrl_4way #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .L2_TIMEOUT(T), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready), .cpu_addr(cpu_addr),
    .cpu_resp_valid(cpu_resp_valid), .cpu_resp_data(cpu_resp_data),
    .cpu_resp_hit(cpu_resp_hit), .cpu_resp_err(cpu_resp_err),
    .l1_read(l1_read), .l1_write_enable(l1_write_enable), .l1_addr(l1_addr),
    .l1_write_data(l1_write_data), .l1_read_data(l1_read_data), .l1_hit(l1_hit),
    .l2_req_valid(l2_req_valid), .l2_req_ready(l2_req_ready), .l2_addr(l2_addr),
    .l2_resp_valid(l2_resp_valid), .l2_resp_data(l2_resp_data),
    .hit_count(hit_count), .miss_count(miss_count), .timeout_count(timeout_count)
  );

  always #5 clk = ~clk;

  // L1 stand-in: registered lookup, write on fill, preload port for the bench.
  bit          l1v [2048];
  bit [DW-1:0] l1d [2048];
  logic          pre_en = 1'b0;
  logic [AW-1:0] pre_a = '0;
  logic [DW-1:0] pre_d = '0;
  always @(posedge clk) begin
    if (l1_read) begin
      l1_hit       <= l1v[l1_addr];
      l1_read_data <= l1d[l1_addr];
    end
    if (l1_write_enable) begin
      l1v[l1_addr] <= 1'b1;
      l1d[l1_addr] <= l1_write_data;
    end
    if (pre_en) begin
      l1v[pre_a] <= 1'b1;
      l1d[pre_a] <= pre_d;
    end
  end

  // Reference model state: what L1 should hold and what the counters should read.
  bit          ref_v [2048];
  bit [DW-1:0] ref_d [2048];
  int e_hits = 0, e_miss = 0, e_to = 0;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  task automatic check_counters(input string tag);
    check({tag, "_hit_count"}, 32'(hit_count), e_hits);
    check({tag, "_miss_count"}, 32'(miss_count), e_miss);
    check({tag, "_timeout_count"}, 32'(timeout_count), e_to);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(cpu_req_ready), 1);
    check({tag, "_idle_outs"},
          32'({cpu_resp_valid, cpu_resp_hit, cpu_resp_err, l1_read, l1_write_enable, l2_req_valid}), 0);
    check({tag, "_buses"}, 32'(cpu_resp_data | l1_write_data | 32'(l1_addr) | 32'(l2_addr)), 0);
    check_counters(tag);
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    pre_en = 1'b1; pre_a = a; pre_d = d;
    ref_v[a] = 1'b1; ref_d[a] = d;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  // One CPU read. d: cycles l2_req_ready is held low; k: L2 wait-timer value at which
  // the response is presented (k >= T means the response comes too late).
  task automatic do_req(input string tag, input logic [AW-1:0] a, input int d, input int k,
                        input logic [DW-1:0] l2data);
    bit eh, ee, efill, done, overlap, busy_ready, stable_ok, inwait;
    logic [DW-1:0] ed, fdata, rdata;
    logic [AW-1:0] la;
    bit rhit, rerr;
    int elat, lat, fills, l2reqs, rc, w, s;
    eh = ref_v[a]; ee = 0; efill = 0; ed = '0;
    if (eh) begin
      ed = ref_d[a]; elat = 3; e_hits = sat(e_hits);
    end else begin
      e_miss = sat(e_miss);
      if (k < T) begin
        ed = l2data; elat = 6 + d + k; efill = 1;
        ref_v[a] = 1'b1; ref_d[a] = l2data;
      end else begin
        ee = 1; elat = 4 + d + T; e_to = sat(e_to);
      end
    end
    @(negedge clk);
    cpu_req_valid = 1'b1; cpu_addr = a;
    @(negedge clk);
    cpu_req_valid = 1'b0;
    done = 0; overlap = 0; busy_ready = 0; stable_ok = 1; inwait = 0;
    fills = 0; l2reqs = 0; rc = 0; w = 0; s = 0; lat = -1;
    fdata = '0; rdata = '0; rhit = 0; rerr = 0; la = '0;
    while (!done && s < 100) begin
      if (l1_read && l1_write_enable) overlap = 1;
      if (cpu_req_ready) busy_ready = 1;
      if (l1_write_enable) begin fills++; fdata = l1_write_data; end
      if (l2_req_valid) begin
        if (l2reqs == 0) la = l2_addr;
        else if (l2_addr !== la) stable_ok = 0;
        l2reqs++;
      end
      if (cpu_resp_valid) begin
        done = 1; lat = s + 1;
        rdata = cpu_resp_data; rhit = cpu_resp_hit; rerr = cpu_resp_err;
      end
      l2_resp_valid = 1'b0;
      if (inwait) begin
        if (w == k) begin l2_resp_valid = 1'b1; l2_resp_data = l2data; end
        w++;
      end
      if (!inwait && l2_req_valid) begin
        l2_req_ready = (rc >= d);
        if (rc < d) begin
          l2_resp_valid = 1'($urandom_range(0, 1));
          l2_resp_data = $urandom;
        end
        rc++;
        if (l2_req_ready) begin inwait = 1; w = 0; end
      end else begin
        l2_req_ready = 1'b0;
      end
      @(negedge clk);
      s++;
    end
    l2_resp_valid = 1'b0; l2_req_ready = 1'b0;
    check({tag, "_resp_seen"}, 32'(done), 1);
    check({tag, "_latency"}, lat, elat);
    check({tag, "_data"}, rdata, ed);
    check({tag, "_hit_err"}, 32'({rhit, rerr}), 32'({eh, ee}));
    check({tag, "_fills"}, fills, 32'(efill));
    if (efill) check({tag, "_fill_data"}, fdata, ed);
    check({tag, "_l2_req_cycles"}, l2reqs, eh ? 0 : d + 1);
    if (!eh) check({tag, "_l2_addr"}, 32'(la), 32'(a));
    check({tag, "_l2_stable"}, 32'(stable_ok), 1);
    check({tag, "_rd_wr_overlap"}, 32'(overlap), 0);
    check({tag, "_ready_while_busy"}, 32'(busy_ready), 0);
    check({tag, "_ready_after"}, 32'(cpu_req_ready), 1);
    check_counters(tag);
  endtask

  // An L2 response while idle must change nothing.
  task automatic stray_resp(input string tag);
    @(negedge clk);
    l2_resp_valid = 1'b1; l2_resp_data = 32'hDEAD_BEEF;
    @(negedge clk);
    l2_resp_valid = 1'b0;
    check({tag, "_no_resp"}, 32'({cpu_resp_valid, l1_write_enable, l1_read}), 0);
    check({tag, "_still_idle"}, 32'(cpu_req_ready), 1);
    check_counters(tag);
  endtask

  task automatic reset_in_wait();
    bit seen;
    @(negedge clk);
    cpu_req_valid = 1'b1; cpu_addr = 11'h7F0;
    @(negedge clk);
    cpu_req_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      l2_req_ready = l2_req_valid;
      @(negedge clk);
    end
    l2_req_ready = 1'b0;
    check("rstwait_in_wait", 32'({cpu_req_ready, l2_req_valid, cpu_resp_valid}), 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    e_hits = 0; e_miss = 0; e_to = 0;
    check_reset_outputs("rstwait");
    seen = 0;
    for (int i = 0; i < T + 6; i++) begin
      if (cpu_resp_valid || l1_write_enable || l2_req_valid) seen = 1;
      @(negedge clk);
    end
    check("rstwait_quiet", 32'(seen), 0);
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    do_req("cold_miss", 11'h010, 0, 2, 32'hCAFE_0001);
    preload(11'h020, 32'h1234_5678);
    do_req("hit", 11'h020, 0, 0, 32'h0);
    do_req("backpressure", 11'h030, 5, 1, 32'hB0B0_0030);
    do_req("timeout", 11'h040, 0, T, 32'h5A5A_0040);
    stray_resp("late_resp");
    do_req("resp_at_limit", 11'h050, 1, T - 1, 32'h0000_0050);
    do_req("refill_hit", 11'h050, 0, 0, 32'h0);

    for (int i = 0; i < 40; i++) begin
      logic [AW-1:0] ra;
      ra = AW'($urandom_range(0, 15));
      do_req("rand", ra, int'($urandom_range(0, 3)), int'($urandom_range(0, T + 1)), $urandom);
    end

    reset_in_wait();
    do_req("after_reset", 11'h7F1, 0, 1, 32'h0F0F_7F11);

    do_req("sat_fill", 11'h7E0, 0, 0, 32'h7E07_E07E);
    for (int i = 0; i < 17; i++) do_req("sat_hit", 11'h7E0, 0, 0, 32'h0);
    check("sat_hit_count_final", 32'(hit_count), 32'hF);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no end of run, expected completion");
    $fatal(1);
  end
endmodule
